// File: rtl/alu_result_queue_if.sv
// Handshake bundle between the ALU result producers, the result queue and writeback.
interface alu_result_queue_if;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_tag;
  logic [3:0]  out_aux;
  logic [5:0]  out_data;
  logic        out_zero;

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_tag, out_aux, out_data, out_zero
  );

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_tag, out_aux, out_data, out_zero
  );
endinterface

// File: rtl/alu_result_queue.sv
// Sanitising FIFO for ALU result words, with head zero flag and shift-result counter.
// Latency: a push into an empty queue is visible on out_* the following cycle.
// Backpressure: in_ready = !full; a full queue refuses pushes even while popping.
module alu_result_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  alu_result_queue_if.slave       bus,
  output logic [$clog2(DEPTH):0]  level,
  output logic [CNT_W-1:0]        shift_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef struct packed {
    logic [1:0] tag;
    logic [3:0] aux;
    logic [5:0] data;
    logic       zero;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           in_entry;
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             is_shift;

  assign full     = (level == LVL_W'(DEPTH));
  assign empty    = (level == '0);
  assign push     = bus.in_valid && !full;
  assign pop      = bus.out_ready && !empty;
  assign is_shift = (bus.in_word[11:10] == 2'b01);

  // Shift-class aux is undefined upstream; force it to zero so nothing unknown is stored.
  always_comb begin
    in_entry      = '0;
    in_entry.tag  = bus.in_word[11:10];
    in_entry.aux  = is_shift ? 4'b0000 : bus.in_word[9:6];
    in_entry.data = bus.in_word[5:0];
    in_entry.zero = (bus.in_word[5:0] == 6'd0);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      shift_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (push && is_shift && (shift_cnt != '1)) begin
        shift_cnt <= shift_cnt + 1'b1;
      end
    end
  end

  // Gating on empty keeps stale storage off the bus, including while reset is held.
  assign head          = empty ? '0 : mem[rd_ptr];
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_tag   = head.tag;
  assign bus.out_aux   = head.aux;
  assign bus.out_data  = head.data;
  assign bus.out_zero  = head.zero;
endmodule

// File: tb/tb_alu_result_queue.sv
// Randomised and directed bench for alu_result_queue against a queue-based reference model.
module tb_alu_result_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic [2:0]       level;
  logic [CNT_W-1:0] shift_cnt;
  int               checks;
  int               errors;

  alu_result_queue_if bus ();

  alu_result_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .level     (level),
    .shift_cnt (shift_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the raw accepted words in order, plus a saturating shift count.
  logic [11:0] mq[$];
  int          mcnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mcnt = 0;
    end else begin
      bit do_push;
      bit do_pop;
      do_push = bus.in_valid && (mq.size() < DEPTH);
      do_pop  = bus.out_ready && (mq.size() > 0);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(bus.in_word);
        if (bus.in_word[11:10] == 2'b01 && mcnt < CNT_MAX) mcnt++;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      logic [11:0] w;
      logic [1:0]  t;
      logic [3:0]  a;
      logic [5:0]  d;
      t = 2'b00; a = 4'h0; d = 6'h00;
      if (mq.size() > 0) begin
        w = mq[0];
        t = w[11:10];
        a = (t == 2'b01) ? 4'h0 : w[9:6];
        d = w[5:0];
      end
      chk("m_in_ready",  {31'd0, bus.in_ready},  {31'd0, mq.size() < DEPTH});
      chk("m_out_valid", {31'd0, bus.out_valid}, {31'd0, mq.size() > 0});
      chk("m_out_tag",   {30'd0, bus.out_tag},   {30'd0, t});
      chk("m_out_aux",   {28'd0, bus.out_aux},   {28'd0, a});
      chk("m_out_data",  {26'd0, bus.out_data},  {26'd0, d});
      chk("m_out_zero",  {31'd0, bus.out_zero},  {31'd0, (mq.size() > 0) && (d == 6'd0)});
      chk("m_level",     {29'd0, level},         mq.size());
      chk("m_shift_cnt", {24'd0, shift_cnt},     mcnt);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_word = 12'h000;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
    chk("rst_in_ready",  {31'd0, bus.in_ready},  1);
    chk("rst_level",     {29'd0, level},         0);
    chk("rst_shift_cnt", {24'd0, shift_cnt},     0);
    chk("rst_out_data",  {26'd0, bus.out_data},  0);
    chk("rst_out_zero",  {31'd0, bus.out_zero},  0);
    rst_n = 1'b1;

    // Single shift-class push: aux masked, counter bumps.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_word = 12'b01_1010_000110;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("t1_out_valid", {31'd0, bus.out_valid}, 1);
    chk("t1_out_tag",   {30'd0, bus.out_tag},   32'h1);
    chk("t1_out_aux",   {28'd0, bus.out_aux},   32'h0);
    chk("t1_out_data",  {26'd0, bus.out_data},  6);
    chk("t1_out_zero",  {31'd0, bus.out_zero},  0);
    chk("t1_shift_cnt", {24'd0, shift_cnt},     1);
    chk("t1_level",     {29'd0, level},         1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Tag 10 keeps aux; zero data sets the flag.
    bus.in_valid = 1'b1;
    bus.in_word = 12'b10_1011_000000;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("t2_out_aux",   {28'd0, bus.out_aux},  32'hb);
    chk("t2_out_zero",  {31'd0, bus.out_zero}, 1);
    chk("t2_shift_cnt", {24'd0, shift_cnt},    1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("t2_level",     {29'd0, level},         0);
    chk("t2_out_valid", {31'd0, bus.out_valid}, 0);
    chk("t2_out_aux",   {28'd0, bus.out_aux},   0);
    chk("t2_out_zero",  {31'd0, bus.out_zero},  0);

    // Fill to DEPTH, hold a fifth word, pop once: fifth refused that edge, taken the next.
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_word = {2'b11, 4'h5, 6'(i + 10)};
      @(negedge clk);
    end
    chk("t3_in_ready", {31'd0, bus.in_ready}, 0);
    chk("t3_level",    {29'd0, level},        4);
    bus.in_word = {2'b00, 4'h9, 6'd14};
    repeat (2) @(negedge clk);
    chk("t3_held_level", {29'd0, level},       4);
    chk("t3_head_data",  {26'd0, bus.out_data}, 10);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("t3_pop_level",  {29'd0, level},        3);
    chk("t3_pop_head",   {26'd0, bus.out_data}, 11);
    chk("t3_pop_ready",  {31'd0, bus.in_ready}, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("t3_fifth_level", {29'd0, level}, 4);
    bus.out_ready = 1'b1;
    repeat (4) @(negedge clk);
    bus.out_ready = 1'b0;
    chk("t3_drain_level", {29'd0, level}, 0);

    // Streaming through pointer wrap: level stays at one, order preserved.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_word = {2'b00, 4'h3, 6'(i + 1)};
      @(negedge clk);
      chk("t4_level",    {29'd0, level},        1);
      chk("t4_out_data", {26'd0, bus.out_data}, i + 1);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("t4_end_level", {29'd0, level}, 0);

    // Randomised traffic, including unknown aux on shift-class words.
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] t;
      logic [5:0] d;
      t = 2'($urandom);
      d = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
      bus.in_valid = ($urandom_range(0, 99) < 60);
      bus.out_ready = ($urandom_range(0, 99) < 50);
      if (t == 2'b01 && $urandom_range(0, 1) == 1)
        bus.in_word = {t, 4'bxxxx, d};
      else
        bus.in_word = {t, 4'($urandom), d};
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) @(negedge clk);

    // Counter saturation with continuous draining.
    for (int i = 0; i < 300; i++) begin
      bus.in_valid = 1'b1;
      bus.in_word = {2'b01, 4'hf, 6'(i)};
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t5_shift_sat", {24'd0, shift_cnt}, 255);
    bus.out_ready = 1'b0;

    // Asynchronous reset with three entries stored.
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_word = {2'b10, 4'h6, 6'(i + 20)};
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("t6_level_pre", {29'd0, level}, 3);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_out_valid", {31'd0, bus.out_valid}, 0);
    chk("t6_level",     {29'd0, level},         0);
    chk("t6_shift_cnt", {24'd0, shift_cnt},     0);
    chk("t6_in_ready",  {31'd0, bus.in_ready},  1);
    chk("t6_out_data",  {26'd0, bus.out_data},  0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_word = 12'b00_0001_101010;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("t6_after_data", {26'd0, bus.out_data}, 42);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_result_queue.md
Name: alu_result_queue

Overview:
- Downstream stage of the ALU operation blocks; consumes the 12-bit operation result words they produce.
- Result word format: tag [11:10], aux [9:6], data [5:0]. Tag 2'b01 marks a shift-class result; its aux field is undefined.
- The block sanitises each accepted word and buffers it in a small FIFO with valid/ready handshakes on both sides.
- It presents the head entry to the writeback logic with a zero flag and keeps a saturating count of shift-class results.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the shift-result statistics counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word; equals !full.
- in_word  input  12  operation result word {tag, aux, data}.
- out_valid  output  1  head entry valid; equals !empty.
- out_ready  input  1  downstream accepts the head entry.
- out_tag  output  2  tag of head entry.
- out_aux  output  4  sanitised aux of head entry.
- out_data  output  6  data of head entry.
- out_zero  output  1  head entry data == 6'd0.
- level  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- shift_cnt  output  CNT_W  saturating count of accepted tag-01 words.

Behaviour:
- Reset (async, rst_n low): read/write pointers = 0, level = 0, shift_cnt = 0, storage contents don't-care.
  - Outputs while in reset: out_valid = 0, out_tag/out_aux/out_data/out_zero = 0, in_ready = 1.
  - Reset mid-operation discards all stored entries immediately.
- Push: occurs when in_valid && in_ready at a rising edge.
  - Stored entry: tag = in_word[11:10] and data = in_word[5:0].
  - Stored aux = 4'b0000 if tag == 2'b01, else in_word[9:6].
  - zero flag = (in_word[5:0] == 0), computed and stored at push.
  - in_word bits with X/undefined value in aux must never propagate for tag 01.
- Pop: occurs when out_valid && out_ready at a rising edge; the read pointer advances.
- Latency: a word pushed at edge t is visible on out_* with out_valid = 1 during cycle t+1 if the FIFO was empty.
  - There is no combinational in-to-out path.
- Outputs are driven from the head entry whenever level > 0. All out_* fields are 0 when empty.
- Level update:
  - push only: +1.
  - pop only: -1.
  - push and pop in same edge: unchanged; both pointers advance.
- Full (level == DEPTH): in_ready = 0.
  - A push is never accepted when full, even if out_ready = 1 in the same cycle.
  - The upstream must hold the word.
- Empty (level == 0): out_valid = 0. A pop is impossible; out_ready is ignored.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0. Level is tracked separately to distinguish full from empty.
- shift_cnt: +1 on every push with tag == 2'b01. Saturates at 2^CNT_W-1. Unaffected by pops; cleared only by reset.
- Tag values 00, 10, 11 pass through unmodified. The block does not interpret them beyond the 01 aux masking.

Test Plan:
- Reset, then a single push of 12'b01_1010_000110 -> next cycle out_valid = 1, out_tag = 01, out_aux = 0000, out_data = 6'd6, out_zero = 0, shift_cnt = 1, level = 1.
- Push 12'b10_1011_000000 and pop it -> out_aux = 1011, out_zero = 1, shift_cnt unchanged; after the pop, level = 0 and out_* = 0.
- Push 5 words with out_ready = 0 (DEPTH = 4) -> in_ready drops after the 4th push, the 5th is held, level = 4.
  - Then assert out_ready for 1 cycle -> the head is popped and the 5th word is not accepted in that same cycle.
  - The 5th word is accepted on the following edge.
- Continuous push and pop of 10 sequential words with both valid/ready high -> output order matches input order across pointer wrap, and level stays constant.
- Push 300 tag-01 words with CNT_W = 8, draining continuously -> shift_cnt saturates at 255.
- Assert rst_n low with 3 entries stored -> out_valid falls immediately (asynchronously), level = 0, shift_cnt = 0, in_ready = 1.
